// File: rtl/scff_chain_loader.sv
// Serial loader for an scff configuration chain: streams words LSB-first onto scan_d/scan_en.
// Optional CRC-8 check of the shifted stream is enabled by defining SCFF_LOADER_CRC_EN.
module scff_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 144
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              scan_d,
    output logic              scan_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              done_d, err_d;
    logic              in_ready_d, scan_en_d, scan_d_d, busy_d;
    logic              last_chain_bit, last_word_bit;
`ifdef SCFF_LOADER_CRC_EN
    logic [7:0]        crc_q, crc_d;
`endif

    assign last_chain_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign last_word_bit  = (wbit_q == WB_W'(WORD_W - 1));

    // Next-state, datapath and next-output decode; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbit_d  = wbit_q;
        sreg_d  = sreg_q;
        done_d  = done;
        err_d   = err;
`ifdef SCFF_LOADER_CRC_EN
        crc_d   = crc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef SCFF_LOADER_CRC_EN
                    crc_d   = 8'h00;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    wbit_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                wbit_d = wbit_q + WB_W'(1);
`ifdef SCFF_LOADER_CRC_EN
                // MSB-first serial CRC-8, polynomial x^8+x^2+x+1
                if (crc_q[7] ^ sreg_q[0]) begin
                    crc_d = {crc_q[6:0], 1'b0} ^ 8'h07;
                end else begin
                    crc_d = {crc_q[6:0], 1'b0};
                end
`endif
                // chain end wins over word end; leftover bits of a truncated word are dropped
                if (last_chain_bit) begin
                    state_d = CHECK;
                end else if (last_word_bit) begin
                    state_d = LOAD;
                end
            end
            CHECK: begin
`ifdef SCFF_LOADER_CRC_EN
                if (in_valid) begin
                    err_d   = (in_data[7:0] != crc_q);
                    state_d = FIN;
                end
`else
                state_d = FIN;
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // done rises together with the FIN cycle and then holds
        if (state_d == FIN) begin
            done_d = 1'b1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end

`ifdef SCFF_LOADER_CRC_EN
        in_ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
        in_ready_d = (state_d == LOAD);
`endif
        scan_en_d = (state_d == SHIFT);
        scan_d_d  = scan_en_d & sreg_d[0];
        busy_d    = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wbit_q   <= '0;
            sreg_q   <= '0;
            in_ready <= 1'b0;
            scan_d   <= 1'b0;
            scan_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef SCFF_LOADER_CRC_EN
            crc_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wbit_q   <= wbit_d;
            sreg_q   <= sreg_d;
            in_ready <= in_ready_d;
            scan_d   <= scan_d_d;
            scan_en  <= scan_en_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
`ifdef SCFF_LOADER_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_scff_chain_loader.sv
// Directed bench for scff_chain_loader (CHAIN_LEN=20, WORD_W=8); CRC cases run when
// SCFF_LOADER_CRC_EN is defined.
module tb_scff_chain_loader;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CHAIN_LEN = 20;
    localparam logic [19:0] EXP_BITS  = 20'hF3CA5;   // 0xA5, 0x3C, low nibble of 0x0F, LSB first

    logic              clk      = 1'b0;
    logic              R        = 1'b1;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [WORD_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, scan_d, scan_en, busy, done, err;

    int total = 0;
    int bad   = 0;

    // chain-side capture: one bit per cycle with scan_en high
    logic sbits [512];
    int   scyc  [512];
    int   nbits = 0;
    int   cyc   = 0;

`ifdef SCFF_LOADER_CRC_EN
    logic [7:0] crc_word = 8'hD7;
`endif

    scff_chain_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN)
    ) dut (
        .clk     (clk),
        .R       (R),
        .start   (start),
        .abort   (abort),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .scan_d  (scan_d),
        .scan_en (scan_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scan_en === 1'b1 && nbits < 512) begin
            sbits[nbits] = scan_d;
            scyc[nbits]  = cyc;
            nbits        = nbits + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer one word, optionally after idling gap cycles in LOAD, and wait for the handshake.
    task automatic send_word(input logic [7:0] w, input int gap);
        bit ok;
        bit seen;
        int n0;
        ok   = 1'b0;
        seen = 1'b0;
        if (gap > 0) begin
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (in_ready === 1'b1) seen = 1'b1;
            end
            n0 = nbits;
            repeat (gap) @(posedge clk);
            #1;
            check_eq("gap_scan_en_idle", 32'(nbits - n0), 32'd0);
        end
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("handshake", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        check_eq("idle_timeout", 32'(idle), 32'd1);
    endtask

    task automatic run_load(input int gap, input bit poke, output int base);
        base = nbits;
        pulse_start();
        send_word(8'hA5, 0);
        if (poke) pulse_start();
        send_word(8'h3C, gap);
        send_word(8'h0F, gap);
`ifdef SCFF_LOADER_CRC_EN
        send_word(crc_word, 0);
`endif
        wait_idle();
    endtask

    task automatic verify_bits(input string tag, input int base, input int exp_span);
        logic [19:0] v;
        int cnt;
        int span;
        v    = '0;
        cnt  = nbits - base;
        span = -1;
        for (int i = 0; i < 20; i++) begin
            if (base + i < nbits) v[i] = sbits[base + i];
        end
        if (cnt > 0) span = scyc[nbits - 1] - scyc[base];
        check_eq({tag, "_count"}, 32'(cnt), 32'd20);
        check_eq({tag, "_bits"}, 32'(v), 32'(EXP_BITS));
        check_eq({tag, "_span"}, 32'(span), 32'(exp_span));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // reset state
        #2 R = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_scan_en", 32'(scan_en), 32'd0);
        check_eq("rst_scan_d", 32'(scan_d), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        R = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_eq("no_load_without_start", 32'(busy), 32'd0);

        // streamed load
        run_load(0, 1'b0, base);
        verify_bits("stream", base, 21);
        check_eq("stream_done", 32'(done), 32'd1);
        check_eq("stream_err", 32'(err), 32'd0);

        // 5-cycle valid gaps between words
        run_load(5, 1'b0, base);
        verify_bits("gap", base, 31);
        check_eq("gap_done", 32'(done), 32'd1);

        // start while busy is ignored
        run_load(0, 1'b1, base);
        verify_bits("poke", base, 21);
        check_eq("poke_done", 32'(done), 32'd1);
        check_eq("poke_err", 32'(err), 32'd0);

        // abort during second word's shift
        pulse_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_err", 32'(err), 32'd1);
        check_eq("abort_scan_en", 32'(scan_en), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("abort_stays_idle", 32'(busy), 32'd0);

        // asynchronous reset mid-shift
        pulse_start();
        send_word(8'hA5, 0);
        repeat (3) @(posedge clk);
        #2 R = 1'b0;
        #1;
        check_eq("arst_scan_en", 32'(scan_en), 32'd0);
        check_eq("arst_scan_d", 32'(scan_d), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        R = 1'b1;
        run_load(0, 1'b0, base);
        verify_bits("reload", base, 21);
        check_eq("reload_done", 32'(done), 32'd1);

`ifdef SCFF_LOADER_CRC_EN
        // correct and corrupted CRC words
        crc_word = 8'hD7;
        run_load(0, 1'b0, base);
        verify_bits("crc_ok", base, 21);
        check_eq("crc_ok_done", 32'(done), 32'd1);
        check_eq("crc_ok_err", 32'(err), 32'd0);
        crc_word = 8'hD6;
        run_load(0, 1'b0, base);
        check_eq("crc_bad_done", 32'(done), 32'd1);
        check_eq("crc_bad_err", 32'(err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scff_chain_loader.md
SCFF_CHAIN_LOADER -- requirements
Module: scff_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, input word width in bits (min 8).
REQ-002 SHALL have parameter CHAIN_LEN, default 144, number of scff cells in the driven chain (min 1).
REQ-003 SHALL have port clk  input  1  rising-edge clock, shared with the scff chain.
REQ-004 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a load in progress.
REQ-007 SHALL have port in_data  input  WORD_W  configuration word, bit 0 shifted first.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 SHALL have port scan_d  output  1  serial data to D of the first scff.
REQ-011 SHALL have port scan_en  output  1  chain clock enable; chain advances one bit on every clk edge where scan_en=1.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  last load completed.
REQ-014 SHALL have port err  output  1  last load failed its check.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, CHECK, FIN.
REQ-016 IDLE: start=1 SHALL clear bit counter, done, err, CRC register, and enter LOAD next cycle; start in any other state SHALL be ignored.
REQ-017 LOAD: in_ready SHALL be 1; on in_valid&in_ready the word SHALL be captured into the shift register and state SHALL become SHIFT.
REQ-018 SHIFT: scan_en SHALL be 1, scan_d SHALL equal shift register bit 0; each cycle register shifts right by one and the bit counter increments.
REQ-019 SHIFT SHALL exit after WORD_W bits of the current word or when the bit counter reaches CHAIN_LEN, whichever first; remaining bits of a truncated word SHALL be discarded.
REQ-020 On SHIFT exit with counter < CHAIN_LEN, next state SHALL be LOAD; with counter = CHAIN_LEN, next state SHALL be CHECK.
REQ-021 Per-word throughput SHALL be WORD_W+1 cycles (1 LOAD handshake + WORD_W SHIFT) with in_valid held high.
REQ-022 scan_en and in_ready SHALL be 0 in IDLE, CHECK and FIN; scan_d SHALL be 0 whenever scan_en=0.
REQ-023 FIN SHALL last one cycle, set done=1, and return to IDLE; done and err SHALL hold until the next accepted start.
REQ-024 busy SHALL be 1 in LOAD, SHIFT, CHECK, FIN and 0 in IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with done=0, err=1; chain contents are then undefined; abort has priority over all other transitions.
REQ-026 Bit counter SHALL be clog2(CHAIN_LEN+1) bits and SHALL never exceed CHAIN_LEN.

Reset
REQ-027 R=0 SHALL asynchronously force state IDLE, bit counter 0, shift register 0, CRC 0, and in_ready, scan_d, scan_en, busy, done, err all 0, including mid-load.
REQ-028 Release of R SHALL take effect at the first clk edge with R=1; no load starts without a subsequent start.

Configuration
REQ-029 With SCFF_LOADER_CRC_EN defined, every bit driven on scan_d during SHIFT SHALL update a CRC-8 (poly 0x07, init 0x00, MSB-first serial); CHECK SHALL assert in_ready, accept one further word, compare its bits [7:0] with the CRC, set err=1 on mismatch, then go to FIN.
REQ-030 Without SCFF_LOADER_CRC_EN, no CRC logic SHALL exist, CHECK SHALL pass directly to FIN in one cycle, and err SHALL be set only by abort.

Verification
REQ-031 CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0x0F streamed -> scan_d sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; scan_en high exactly 20 cycles; done=1, err=0.
REQ-032 Same load with in_valid deasserted for 5 cycles between words -> scan_en low during gap, identical 20-bit sequence, done=1.
REQ-033 abort pulsed during second word's SHIFT -> next cycle state IDLE, busy=0, done=0, err=1, scan_en=0.
REQ-034 R driven low mid-SHIFT -> all outputs 0 immediately (without clk edge); start after release re-loads full 20 bits.
REQ-035 start asserted while busy -> ignored, bit sequence unchanged.
REQ-036 With SCFF_LOADER_CRC_EN: correct CRC word -> err=0, done=1; CRC word with one bit flipped -> err=1, done=1.
